hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Drives the stall/flush/clear and forwarding controls of the pipeline registers (F/D/E/M/W) of the
//  5-stage pipelined MIPS core. Detects RAW data hazards, load-use and branch-compare hazards, and
//  freezes the whole pipeline while a multi-cycle data-memory access in stage M is outstanding.
//  Sits beside the datapath; all hazard detection is combinational except the memory-wait FSM.
// PARAMETERS
//  MEM_WAIT  2  extra wait cycles per data-memory access in M (0 = single-cycle memory, FSM idle)
// PORTS
//  clk          in   1  clock; all state updates on rising edge
//  reset        in   1  asynchronous, active-high reset
//  RsD,RtD      in   5  source regs of instruction in D
//  RsE,RtE      in   5  source regs of instruction in E
//  WriteRegE/M/W in  5  destination reg in E/M/W
//  RegWriteE/M/W in  1  destination write enable in E/M/W
//  MemtoRegE/M  in   1  load in E/M
//  MemWriteM    in   1  store in M
//  BranchD      in   1  branch in D (compare in D)
//  PCSrcD       in   1  branch taken, resolved in D
//  StallF,StallD out 1  hold PC / D register
//  StallE,StallM,StallW out 1  hold E/M/W registers (memory wait only)
//  FlushE       out  1  zero E register (bubble)
//  RegClrD      out  1  zero D register (squash fetched instr after taken branch)
//  ForwardAD,ForwardBD out 1  D-stage compare operand from ALUOutM
//  ForwardAE,ForwardBE out 2  E-stage ALU operand select (fwd_sel_t)
// BEHAVIOUR
//  - Forward E: FWD_MEM if Rs/RtE!=0 & ==WriteRegM & RegWriteM; else FWD_WB if ==WriteRegW & RegWriteW;
//    else FWD_RF. M has priority over W. Register 0 never forwarded.
//  - Forward D: ForwardAD = RsD!=0 & RsD==WriteRegM & RegWriteM (BD same with RtD).
//  - lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
//  - brstall = BranchD & ((RegWriteE & WriteRegE in {RsD,RtD}) | (MemtoRegM & WriteRegM in {RsD,RtD})).
//  - memstall = FSM in WAIT, or FSM in IDLE with (MemtoRegM|MemWriteM) and MEM_WAIT>0.
//  - Priority: memstall -> StallF..StallW=1, FlushE=0, RegClrD=0 (full freeze, W held so W forwarding
//    stays valid; repeated RF write of same value is harmless). Else lwstall|brstall -> StallF=StallD=1,
//    FlushE=1. Else none. RegClrD = PCSrcD & ~StallD & ~memstall.
//  - Memory FSM (mem_state_t): IDLE --access in M, MEM_WAIT>0--> WAIT, cnt<=MEM_WAIT-1.
//    WAIT: cnt==0 -> DONE else cnt--. DONE: 1 cycle, no memstall, pipeline advances; -> IDLE
//    (DONE ignores access in M since it is the completing instr). Access occupies M for MEM_WAIT+1 cycles.
//  - Back-to-back memory instrs: second reaches M while FSM in IDLE (after DONE) -> new wait.
//  - Counter width $clog2(MEM_WAIT+1) (min 1).
//  - Reset (any time, incl. mid-WAIT): state=IDLE, cnt=0 asynchronously; while reset=1 all stall,
//    flush, clear and forward outputs are 0.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds out ports StallCnt[31:0] (cycles with StallF=1) and FlushCnt[31:0]
//  (cycles with FlushE=1 or RegClrD=1); wrap on overflow, reset to 0.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  hazard_pkg: typedef enum logic[1:0] fwd_sel_t {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10};
//  typedef enum logic[1:0] mem_state_t {IDLE, WAIT, DONE}.
//  Sub-module mem_wait_fsm (clk, reset, access, memstall): FSM + counter; rest combinational in top.
// TESTING
//  1 RegWriteM=1,WriteRegM=8,RsE=8 and RegWriteW=1,WriteRegW=8 -> ForwardAE=FWD_MEM; RsE=0 -> FWD_RF.
//  2 MemtoRegE=1,RtE=9,RsD=9 -> StallF=StallD=FlushE=1, StallE=0; next cycle MemtoRegE=0 -> all 0.
//  3 BranchD=1,RegWriteE=1,WriteRegE=4,RtD=4 -> brstall; PCSrcD=1 with no stall -> RegClrD=1.
//  4 MEM_WAIT=2, MemtoRegM=1 held -> memstall high 2 cycles (IDLE,WAIT,WAIT? => exactly MEM_WAIT
//    cycles), then DONE cycle all stalls 0; lwstall concurrent -> FlushE=0 during freeze.
//  5 Reset asserted during WAIT -> outputs 0 immediately, FSM IDLE; release with no access -> no stall.
//  6 HAZARD_PERF_EN: 3 lwstall cycles + 1 taken branch -> StallCnt=3, FlushCnt=4; reset -> both 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
//   fwd_sel_t   : E-stage ALU operand source (register file, W result, M result)
//   mem_state_t : data-memory wait FSM state
//   fwd_select  : E-stage forwarding decision for one source register
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } mem_state_t;

  // M has priority over W (newer value); register 0 is never forwarded.
  function automatic fwd_sel_t fwd_select(
    input logic [4:0] src,
    input logic [4:0] wr_m,
    input logic       we_m,
    input logic [4:0] wr_w,
    input logic       we_w
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (src != 5'd0) begin
      if (we_m && (src == wr_m))
        sel = FWD_MEM;
      else if (we_w && (src == wr_w))
        sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait sequencer. Holds the pipeline while a multi-cycle load or
// store sits in stage M, then releases it for one completing cycle (DONE).
// Ports:
//   clk      in  clock, rising edge
//   reset    in  asynchronous active-high reset (state IDLE, counter 0)
//   access   in  load or store present in stage M
//   memstall out freeze request for the whole pipeline
// Parameter MEM_WAIT: stall cycles per access (0 = single-cycle memory).
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic access,
  output logic memstall
);

  localparam int unsigned CW     = (MEM_WAIT == 0) ? 1 : $clog2(MEM_WAIT + 1);
  localparam bit          MEM_EN = (MEM_WAIT != 0);
  localparam logic [CW-1:0] LOAD = CW'((MEM_WAIT > 1) ? (MEM_WAIT - 1) : 0);
  localparam logic [CW-1:0] ONE  = CW'(1);

  mem_state_t      state_q;
  logic [CW-1:0]   cnt_q;

  // The IDLE cycle that detects the access is itself the first stall cycle,
  // so cnt holds the stall cycles still owed in WAIT (including the current
  // one); total freeze is exactly MEM_WAIT cycles followed by DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access && MEM_EN) begin
            cnt_q   <= LOAD;
            state_q <= (MEM_WAIT == 1) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q <= ONE)
            state_q <= DONE;
          else
            cnt_q <= cnt_q - ONE;
        end
        DONE: begin
          // Access still seen here belongs to the completing instruction.
          state_q <= IDLE;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    memstall = 1'b0;
    if (state_q == WAIT)
      memstall = 1'b1;
    else if ((state_q == IDLE) && access && MEM_EN)
      memstall = 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit of the 5-stage MIPS pipeline: forwarding selects, load-use and
// branch-compare stalls, taken-branch squash, and full-pipeline freeze while a
// multi-cycle data-memory access is outstanding in M.
// Ports:
//   clk, reset                 clock / async active-high reset
//   RsD, RtD, RsE, RtE         source registers in D and E
//   WriteRegE/M/W, RegWriteE/M/W  destination register and write enable per stage
//   MemtoRegE/M, MemWriteM     load in E/M, store in M
//   BranchD, PCSrcD            branch in D, branch taken
//   StallF..StallW, FlushE, RegClrD  pipeline register controls
//   ForwardAD/BD               D-stage compare operand from ALUOutM
//   ForwardAE/BE               E-stage operand select (fwd_sel_t encoding)
// Optional macro HAZARD_PERF_EN adds StallCnt / FlushCnt event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       MemWriteM,
  input  logic       BranchD,
  input  logic       PCSrcD,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       StallW,
  output logic       FlushE,
  output logic       RegClrD,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
`endif
);

  logic     memstall;
  logic     lwstall;
  logic     brstall;
  logic     fwd_ad;
  logic     fwd_bd;
  fwd_sel_t fwd_ae;
  fwd_sel_t fwd_be;

  mem_wait_fsm #(
    .MEM_WAIT (MEM_WAIT)
  ) u_mem_wait_fsm (
    .clk      (clk),
    .reset    (reset),
    .access   (MemtoRegM | MemWriteM),
    .memstall (memstall)
  );

  always_comb begin
    fwd_ae = fwd_select(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
    fwd_be = fwd_select(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
    fwd_ad = (RsD != 5'd0) && (RsD == WriteRegM) && RegWriteM;
    fwd_bd = (RtD != 5'd0) && (RtD == WriteRegM) && RegWriteM;
  end

  always_comb begin
    lwstall = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
    brstall = BranchD &&
              ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
               (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));
  end

  // Freeze holds W as well so W-stage forwarding stays valid during the wait.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    StallW    = 1'b0;
    FlushE    = 1'b0;
    RegClrD   = 1'b0;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (!reset) begin
      if (memstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        StallW = 1'b1;
      end else if (lwstall || brstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
      RegClrD   = PCSrcD && !StallD && !memstall;
      ForwardAD = fwd_ad;
      ForwardBD = fwd_bd;
      ForwardAE = fwd_ae;
      ForwardBE = fwd_be;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF)
        StallCnt <= StallCnt + 32'd1;
      if (FlushE || RegClrD)
        FlushCnt <= FlushCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM;
  logic       BranchD, PCSrcD;
  logic       StallF, StallD, StallE, StallM, StallW, FlushE, RegClrD;
  logic       ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  // {StallF,StallD,StallE,StallM,StallW,FlushE,RegClrD}
  logic [6:0] ctl;
  // {ForwardAD,ForwardBD,ForwardAE,ForwardBE}
  logic [5:0] fwd;
  assign ctl = {StallF, StallD, StallE, StallM, StallW, FlushE, RegClrD};
  assign fwd = {ForwardAD, ForwardBD, ForwardAE, ForwardBE};

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MEM_WAIT (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .RsD       (RsD),
    .RtD       (RtD),
    .RsE       (RsE),
    .RtE       (RtE),
    .WriteRegE (WriteRegE),
    .WriteRegM (WriteRegM),
    .WriteRegW (WriteRegW),
    .RegWriteE (RegWriteE),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .MemtoRegE (MemtoRegE),
    .MemtoRegM (MemtoRegM),
    .MemWriteM (MemWriteM),
    .BranchD   (BranchD),
    .PCSrcD    (PCSrcD),
    .StallF    (StallF),
    .StallD    (StallD),
    .StallE    (StallE),
    .StallM    (StallM),
    .StallW    (StallW),
    .FlushE    (FlushE),
    .RegClrD   (RegClrD),
    .ForwardAD (ForwardAD),
    .ForwardBD (ForwardBD),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE)
`ifdef HAZARD_PERF_EN
    ,
    .StallCnt  (StallCnt),
    .FlushCnt  (FlushCnt)
`endif
  );

  task automatic clear_inputs();
    RsD = 5'd0; RtD = 5'd0; RsE = 5'd0; RtE = 5'd0;
    WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0;
    BranchD = 1'b0; PCSrcD = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    MemtoRegE = 1'b1; RtE = 5'd9; RsD = 5'd9;
    RegWriteM = 1'b1; WriteRegM = 5'd8; RsE = 5'd8; RtD = 5'd8;
    #2;
    total++;
    if (ctl !== 7'b0000000) begin
      bad++; $display("FAIL reset_ctl got=%b want=%b", ctl, 7'b0000000);
    end
    total++;
    if (fwd !== 6'b000000) begin
      bad++; $display("FAIL reset_fwd got=%b want=%b", fwd, 6'b000000);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    step();
    total++;
    if (ctl !== 7'b0000000) begin
      bad++; $display("FAIL post_reset_idle got=%b want=%b", ctl, 7'b0000000);
    end
  endtask

  task automatic test_forward();
    clear_inputs();
    RegWriteM = 1'b1; WriteRegM = 5'd8; RsE = 5'd8;
    RegWriteW = 1'b1; WriteRegW = 5'd8;
    #1;
    total++;
    if (ForwardAE !== 2'b10) begin
      bad++; $display("FAIL fwd_ae_mem_prio got=%b want=%b", ForwardAE, 2'b10);
    end
    RsE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
    #1;
    total++;
    if (ForwardAE !== 2'b00) begin
      bad++; $display("FAIL fwd_ae_r0 got=%b want=%b", ForwardAE, 2'b00);
    end
    RegWriteM = 1'b0; WriteRegM = 5'd8; WriteRegW = 5'd8; RtE = 5'd8; RsE = 5'd3;
    #1;
    total++;
    if ({ForwardAE, ForwardBE} !== 4'b0001) begin
      bad++; $display("FAIL fwd_be_wb got=%b want=%b", {ForwardAE, ForwardBE}, 4'b0001);
    end
    clear_inputs();
    RegWriteM = 1'b1; WriteRegM = 5'd8; RsD = 5'd8; RtD = 5'd8;
    #1;
    total++;
    if ({ForwardAD, ForwardBD} !== 2'b11) begin
      bad++; $display("FAIL fwd_d_both got=%b want=%b", {ForwardAD, ForwardBD}, 2'b11);
    end
    WriteRegM = 5'd0; RsD = 5'd0; RtD = 5'd5;
    #1;
    total++;
    if ({ForwardAD, ForwardBD} !== 2'b00) begin
      bad++; $display("FAIL fwd_d_r0 got=%b want=%b", {ForwardAD, ForwardBD}, 2'b00);
    end
    clear_inputs();
  endtask

  task automatic test_lwstall();
    step();
    clear_inputs();
    MemtoRegE = 1'b1; RtE = 5'd9; RsD = 5'd9;
    #1;
    total++;
    if (ctl !== 7'b1100010) begin
      bad++; $display("FAIL lwstall got=%b want=%b", ctl, 7'b1100010);
    end
    step();
    MemtoRegE = 1'b0;
    #1;
    total++;
    if (ctl !== 7'b0000000) begin
      bad++; $display("FAIL lwstall_clear got=%b want=%b", ctl, 7'b0000000);
    end
  endtask

  task automatic test_branch();
    step();
    clear_inputs();
    BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd4; RtD = 5'd4; PCSrcD = 1'b1;
    #1;
    total++;
    if (ctl !== 7'b1100010) begin
      bad++; $display("FAIL brstall got=%b want=%b", ctl, 7'b1100010);
    end
    RegWriteE = 1'b0;
    #1;
    total++;
    if (ctl !== 7'b0000001) begin
      bad++; $display("FAIL branch_taken_clr got=%b want=%b", ctl, 7'b0000001);
    end
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    step();
    clear_inputs();
    MemtoRegM = 1'b1; MemtoRegE = 1'b1; RtE = 5'd9; RsD = 5'd9; PCSrcD = 1'b1;
    #1;
    total++;
    if (ctl !== 7'b1111100) begin
      bad++; $display("FAIL mem_freeze_c0 got=%b want=%b", ctl, 7'b1111100);
    end
    step();
    total++;
    if (ctl !== 7'b1111100) begin
      bad++; $display("FAIL mem_freeze_c1 got=%b want=%b", ctl, 7'b1111100);
    end
    step();
    MemtoRegE = 1'b0; PCSrcD = 1'b0;
    #1;
    total++;
    if (ctl !== 7'b0000000) begin
      bad++; $display("FAIL mem_done got=%b want=%b", ctl, 7'b0000000);
    end
  endtask

  task automatic test_back_to_back();
    // MemtoRegM stays high from test_mem_wait: a second access after DONE.
    step();
    total++;
    if (ctl !== 7'b1111100) begin
      bad++; $display("FAIL b2b_c0 got=%b want=%b", ctl, 7'b1111100);
    end
    step();
    total++;
    if (ctl !== 7'b1111100) begin
      bad++; $display("FAIL b2b_c1 got=%b want=%b", ctl, 7'b1111100);
    end
    step();
    total++;
    if (ctl !== 7'b0000000) begin
      bad++; $display("FAIL b2b_done got=%b want=%b", ctl, 7'b0000000);
    end
    MemtoRegM = 1'b0;
    step();
    total++;
    if (ctl !== 7'b0000000) begin
      bad++; $display("FAIL b2b_idle got=%b want=%b", ctl, 7'b0000000);
    end
  endtask

  task automatic test_reset_midwait();
    step();
    clear_inputs();
    MemWriteM = 1'b1;
    RegWriteM = 1'b1; WriteRegM = 5'd8; RsE = 5'd8;
    step();
    total++;
    if (StallM !== 1'b1) begin
      bad++; $display("FAIL midwait_stall got=%b want=%b", StallM, 1'b1);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({ctl, fwd} !== 13'd0) begin
      bad++; $display("FAIL midwait_reset got=%b want=%b", {ctl, fwd}, 13'd0);
    end
    clear_inputs();
    #1;
    reset = 1'b0;
    #1;
    total++;
    if (ctl !== 7'b0000000) begin
      bad++; $display("FAIL midwait_release got=%b want=%b", ctl, 7'b0000000);
    end
    step();
    total++;
    if (ctl !== 7'b0000000) begin
      bad++; $display("FAIL midwait_idle got=%b want=%b", ctl, 7'b0000000);
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    step();
    clear_inputs();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    total++;
    if ({StallCnt, FlushCnt} !== 64'd0) begin
      bad++; $display("FAIL perf_reset0 got=%0d/%0d want=0/0", StallCnt, FlushCnt);
    end
    step();
    MemtoRegE = 1'b1; RtE = 5'd9; RsD = 5'd9;
    step();
    step();
    step();
    clear_inputs();
    PCSrcD = 1'b1;
    step();
    PCSrcD = 1'b0;
    step();
    total++;
    if (StallCnt !== 32'd3) begin
      bad++; $display("FAIL perf_stallcnt got=%0d want=%0d", StallCnt, 3);
    end
    total++;
    if (FlushCnt !== 32'd4) begin
      bad++; $display("FAIL perf_flushcnt got=%0d want=%0d", FlushCnt, 4);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({StallCnt, FlushCnt} !== 64'd0) begin
      bad++; $display("FAIL perf_reset got=%0d/%0d want=0/0", StallCnt, FlushCnt);
    end
    #1;
    reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_forward();
    test_lwstall();
    test_branch();
    test_mem_wait();
    test_back_to_back();
    test_reset_midwait();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
